// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int PC_W           = 32;
    localparam int IF_ENTRY_WIDTH = 64;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;

    // One buffered fetch result: the instruction word and the address it came from
    typedef struct packed {
        logic [31:0]     instruction;
        logic [PC_W-1:0] pc;
    } if_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] raw);
        return raw & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect from
// execute, and the valid/ready hand-off to decode.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     instruction;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_en, redirect_pc,
        output if_valid,
        input  if_ready,
        output instruction, pc, pc_4
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_en, redirect_pc,
        input  if_valid,
        output if_ready,
        input  instruction, pc, pc_4
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries.
// The head is read straight from the storage registers, so an entry is
// visible the cycle after it is pushed. Flush empties it in one cycle.
module inst_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy tracking; flush behaves like reset for the pointers
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Entry storage; a push while full and popping reuses the slot being freed
    always_ff @(posedge clk) begin
        if (reset && !flush && push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory under a credit limit, buffers responses with their PC and presents
// them to decode. A redirect flushes the buffer and marks every request still
// in flight as stale so its response is dropped on arrival.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master fetch_bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    logic             issue;
    logic             rsp_ok;
    logic             push;
    logic             pop;
    logic             show_head;
    logic [CNT_W:0]   in_use;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    if_entry_t        push_entry;
    if_entry_t        head_entry;

    // A slot is committed per request in flight plus per buffered entry, so the
    // buffer can never overflow; a pop this cycle frees one slot immediately.
    assign show_head = reset && !fifo_empty;
    assign fetch_bus.if_valid = show_head && !fetch_bus.redirect_en;
    assign pop       = fetch_bus.if_valid && fetch_bus.if_ready;
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - (CNT_W+1)'(pop);

    assign fetch_bus.imem_req  = reset && !fetch_bus.redirect_en
                                 && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign fetch_bus.imem_addr = fetch_pc;
    assign issue               = fetch_bus.imem_req && fetch_bus.imem_gnt;

    // A response with nothing in flight is ignored; stale ones are dropped.
    assign rsp_ok     = fetch_bus.imem_rvalid && (outstanding != '0);
    assign push       = reset && rsp_ok && (discard == '0) && !fetch_bus.redirect_en;
    assign push_entry = '{instruction: fetch_bus.imem_rdata, pc: resp_pc};

    assign fetch_bus.instruction = show_head ? head_entry.instruction : '0;
    assign fetch_bus.pc          = show_head ? head_entry.pc : '0;
    assign fetch_bus.pc_4        = show_head ? head_entry.pc + PC_STEP : '0;

    // PC, response PC and the in-flight / stale-response counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (fetch_bus.redirect_en) begin
            fetch_pc    <= align_pc(fetch_bus.redirect_pc);
            resp_pc     <= align_pc(fetch_bus.redirect_pc);
            outstanding <= outstanding - CNT_W'(rsp_ok);
            discard     <= outstanding - CNT_W'(rsp_ok);
        end else begin
            if (issue) fetch_pc <= fetch_pc + PC_STEP;
            if (push)  resp_pc  <= resp_pc + PC_STEP;
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_ok);
            if (rsp_ok && (discard != '0)) discard <= discard - CNT_W'(1);
        end
    end

    inst_fetch_fifo #(
        .WIDTH (IF_ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (fetch_bus.redirect_en),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Protocol and credit invariants
    a_rsp_in_flight: assert property (@(posedge clk) disable iff (!reset)
        fetch_bus.imem_rvalid |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (!fifo_full || pop));
    a_issue_credit: assert property (@(posedge clk) disable iff (!reset)
        issue |-> (outstanding < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a fixed-latency in-order memory model plus a
// scoreboard that predicts every issued address and every delivered entry.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    logic clk;
    logic reset;
    inst_fetch_if bus();

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bus)
    );

    int          checks = 0;
    int          fails  = 0;
    int          cycle  = 0;
    int          mem_lat = 1;
    int          issue_count = 0;
    int          pop_count = 0;
    mem_req_t    mem_q[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;
    logic [31:0] s_instr;

    vec_t t1_vec [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // One clock cycle: drive the memory response, sample, score, advance.
    task automatic step();
        mem_req_t r;
        if (!reset) mem_q.delete();
        if (reset && mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = ~mem_q[0].addr;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        s_pc    = bus.pc;
        s_pc4   = bus.pc_4;
        s_instr = bus.instruction;
        if (!reset) begin
            checkOutput("rst_req", s_req, 0);
            checkOutput("rst_valid", s_valid, 0);
            checkOutput("rst_instr", s_instr, 0);
            checkOutput("rst_pc", s_pc, 0);
            checkOutput("rst_pc4", s_pc4, 0);
            exp_addr = RESET_PC;
            exp_pc   = RESET_PC;
        end else begin
            if (bus.imem_rvalid) void'(mem_q.pop_front());
            if (bus.redirect_en) begin
                checkOutput("redir_req", s_req, 0);
                checkOutput("redir_valid", s_valid, 0);
                exp_addr = bus.redirect_pc & ~32'h3;
                exp_pc   = bus.redirect_pc & ~32'h3;
            end else begin
                if (s_req && bus.imem_gnt) begin
                    checkOutput("issue_addr", s_addr, exp_addr);
                    r.addr = s_addr;
                    r.due  = cycle + mem_lat;
                    mem_q.push_back(r);
                    exp_addr = exp_addr + 32'd4;
                    issue_count++;
                end
                if (s_valid && bus.if_ready) begin
                    checkOutput("pop_pc", s_pc, exp_pc);
                    checkOutput("pop_instr", s_instr, ~exp_pc);
                    checkOutput("pop_pc4", s_pc4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    pop_count++;
                end
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic rdy, input logic gnt);
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;
        bus.if_ready    = rdy;
        bus.imem_gnt    = gnt;
        step();
    endtask

    task automatic resetDut(input int lat, input int cycles);
        mem_lat = lat;
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int stale_cycles;

        // gnt, ready, exp_req, exp_addr, exp_valid, exp_pc, exp_pc4
        t1_vec[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
        t1_vec[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h00};
        t1_vec[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h04};
        t1_vec[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h08};
        t1_vec[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0C};
        t1_vec[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h10};
        t1_vec[6] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h14};
        t1_vec[7] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h14};

        reset           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b0;
        exp_addr        = RESET_PC;
        exp_pc          = RESET_PC;
        @(negedge clk);

        $display("[TB] streaming with single-cycle memory");
        resetDut(1, 2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, t1_vec[i].ready, t1_vec[i].gnt);
            checkOutput($sformatf("t1_req[%0d]", i), s_req, t1_vec[i].exp_req);
            if (t1_vec[i].exp_req) checkOutput($sformatf("t1_addr[%0d]", i), s_addr, t1_vec[i].exp_addr);
            checkOutput($sformatf("t1_valid[%0d]", i), s_valid, t1_vec[i].exp_valid);
            if (t1_vec[i].exp_valid) begin
                checkOutput($sformatf("t1_pc[%0d]", i), s_pc, t1_vec[i].exp_pc);
                checkOutput($sformatf("t1_pc4[%0d]", i), s_pc4, t1_vec[i].exp_pc4);
            end
        end

        $display("[TB] decode stall fills the buffer");
        resetDut(1, 2);
        base = issue_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            if (i >= 2) begin
                checkOutput("t2_stall_valid", s_valid, 1);
                checkOutput("t2_stall_pc", s_pc, 32'h0);
            end
        end
        checkOutput("t2_issued", issue_count - base, DEPTH);
        checkOutput("t2_req_low", s_req, 0);
        base = pop_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            checkOutput("t2_drain_valid", s_valid, 1);
        end
        checkOutput("t2_drained", pop_count - base, 8);

        $display("[TB] redirect with two requests in flight");
        resetDut(3, 2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h103, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t3_req", s_req, 1);
        checkOutput("t3_addr", s_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            checkOutput("t3_no_valid", s_valid, 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t3_first_valid", s_valid, 1);
        checkOutput("t3_first_pc", s_pc, 32'h100);

        $display("[TB] redirect against a live response and back-to-back redirects");
        resetDut(1, 2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_empty_after", s_valid, 0);
        checkOutput("t4_addr_200", s_addr, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_gap", s_valid, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_pc_200", s_pc, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_addr_80", s_addr, 32'h80);
        checkOutput("t4_valid_a", s_valid, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_valid_b", s_valid, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_pc_80", s_pc, 32'h80);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] PC wrap at the top of the address space");
        resetDut(1, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_addr0", s_addr, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_addr1", s_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_addr2", s_addr, 32'h0000_0000);
        checkOutput("t5_pc0", s_pc, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_pc1", s_pc, 32'hFFFF_FFFC);
        checkOutput("t5_pc1_4", s_pc4, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t5_pc2", s_pc, 32'h0000_0000);
        checkOutput("t5_pc2_4", s_pc4, 32'h0000_0004);

        $display("[TB] reset pulse with requests in flight");
        resetDut(3, 2);
        stale_cycles = 0;
        while (mem_q.size() < 3 && stale_cycles < 60) begin
            applyStimulus(1'b0, 32'h0, 1'b1,
                          (stale_cycles >= 8) ? 1'b1 : 1'($urandom_range(0, 1)));
            stale_cycles++;
        end
        checkOutput("t6_inflight", mem_q.size(), 3);
        resetDut(3, 3);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
        checkOutput("t6_restart_req", s_req, 1);
        checkOutput("t6_restart_addr", s_addr, RESET_PC);
        base = pop_count;
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
        checkOutput("t6_progress", (pop_count - base) >= 5, 1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
